// File: rtl/text_pkg.sv
// Shared constants, control codes and FSM state type for the text cursor controller.
package text_pkg;

  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 30;
  localparam int unsigned CELLS      = COLS * ROWS;
  localparam int unsigned FIRST_CELL = COLS;
  localparam int unsigned ADDR_W     = 12;

  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] FF       = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StScrRd,
    StScrWr,
    StBlank
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/kb_edge.sv
// Four-bit registered rising-edge detector for the arrow-key levels.
module kb_edge (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] lvl_i,
  output logic [3:0] rise_o
);

  logic [3:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
    end else begin
      prev_q <= lvl_i;
    end
  end

  assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/text_cursor_ctrl.sv
// Text-mode cursor controller: writes typed characters, handles control codes and arrows,
// clears the screen and scrolls rows 2..29 up when the cursor runs off the bottom.
module text_cursor_ctrl #(
  parameter int unsigned COLS = text_pkg::COLS,
  parameter int unsigned ROWS = text_pkg::ROWS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  ascii_in,
  input  logic [15:0] kbsig,
  output logic        in_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [11:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [11:0] cursor,
  output logic        busy
);

  import text_pkg::*;

  localparam int unsigned NCELL = COLS * ROWS;
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);

  localparam logic [ADDR_W-1:0] A_COLS    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] A_FIRST   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(NCELL - 1);
  localparam logic [ADDR_W-1:0] A_SCROLL  = ADDR_W'(NCELL - COLS);
  localparam logic [ADDR_W-1:0] A_SCR_END = ADDR_W'(NCELL - COLS - 1);
  localparam logic [CW-1:0]     C_LAST    = CW'(COLS - 1);
  localparam logic [RW-1:0]     R_FIRST   = RW'(1);
  localparam logic [RW-1:0]     R_LAST    = RW'(ROWS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              start_scroll;
  logic [3:0]        kb_rise;
  logic              unused_kb;

  assign unused_kb = ^{kbsig[15:9], kbsig[4:0]};

  // Arrow order in the detector: {up, down, left, right}.
  kb_edge u_kb_edge (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .lvl_i  (kbsig[8:5]),
    .rise_o (kb_rise)
  );

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_addr_d    = rd_addr_q;
    start_scroll = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_printable(ascii_in)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_q;
            wr_data_d = ascii_in;
            if (cursor_q == A_LAST) begin
              start_scroll = 1'b1;
            end else begin
              cursor_d = cursor_q + 12'd1;
              if (col_q == C_LAST) begin
                col_d = '0;
                row_d = row_q + R_FIRST;
              end else begin
                col_d = col_q + CW'(1);
              end
            end
          end else if (ascii_in == CR) begin
            if (row_q == R_LAST) begin
              start_scroll = 1'b1;
            end else begin
              cursor_d = cursor_q - ADDR_W'(col_q) + A_COLS;
              col_d    = '0;
              row_d    = row_q + R_FIRST;
            end
          end else if (ascii_in == BS) begin
            if (cursor_q > A_COLS) begin
              cursor_d  = cursor_q - 12'd1;
              wr_en_d   = 1'b1;
              wr_addr_d = cursor_q - 12'd1;
              wr_data_d = SPACE;
              if (col_q == '0) begin
                col_d = C_LAST;
                row_d = row_q - R_FIRST;
              end else begin
                col_d = col_q - CW'(1);
              end
            end
          end else if (ascii_in == FF) begin
            state_d = StClear;
            addr_d  = A_FIRST;
          end
        end else if (kb_rise[3]) begin
          if (row_q > R_FIRST) begin
            cursor_d = cursor_q - A_COLS;
            row_d    = row_q - R_FIRST;
          end
        end else if (kb_rise[2]) begin
          if (row_q < R_LAST) begin
            cursor_d = cursor_q + A_COLS;
            row_d    = row_q + R_FIRST;
          end
        end else if (kb_rise[1]) begin
          if (col_q != '0) begin
            cursor_d = cursor_q - 12'd1;
            col_d    = col_q - CW'(1);
          end
        end else if (kb_rise[0]) begin
          if (col_q != C_LAST) begin
            cursor_d = cursor_q + 12'd1;
            col_d    = col_q + CW'(1);
          end
        end
      end

      StClear: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = SPACE;
        if (addr_q == A_LAST) begin
          state_d  = StIdle;
          cursor_d = A_FIRST;
          col_d    = '0;
          row_d    = R_FIRST;
        end else begin
          addr_d = addr_q + 12'd1;
        end
      end

      StScrRd: begin
        state_d = StScrWr;
      end

      // rd_data here answers the rd_addr presented during the preceding StScrRd cycle.
      StScrWr: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = rd_data;
        if (addr_q == A_SCR_END) begin
          state_d = StBlank;
          addr_d  = A_SCROLL;
        end else begin
          state_d   = StScrRd;
          addr_d    = addr_q + 12'd1;
          rd_addr_d = addr_q + 12'd1 + A_COLS;
        end
      end

      StBlank: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = SPACE;
        if (addr_q == A_LAST) begin
          state_d = StIdle;
        end else begin
          addr_d = addr_q + 12'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Cursor parks at the start of the last row while the screen shifts up.
    if (start_scroll) begin
      state_d   = StScrRd;
      cursor_d  = A_SCROLL;
      col_d     = '0;
      row_d     = R_LAST;
      addr_d    = A_FIRST;
      rd_addr_d = A_FIRST + A_COLS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cursor_q  <= A_FIRST;
      col_q     <= '0;
      row_q     <= R_FIRST;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = !in_ready;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = rd_addr_q;
  assign cursor   = cursor_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl with a behavioural text-buffer model.
module tb_text_cursor_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  ascii_in;
  logic [15:0] kbsig;
  logic        in_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic [11:0] cursor;
  logic        busy;

  logic [7:0]  mem [0:2399];
  logic        load_req;
  int          wr_count;
  int          row0_wr;
  int          tests_run;
  int          tests_failed;

  always #5 clk = ~clk;

  text_cursor_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .ascii_in (ascii_in),
    .kbsig    (kbsig),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cursor   (cursor),
    .busy     (busy)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  initial begin
    wr_count = 0;
    row0_wr  = 0;
  end

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 2400; i++) mem[i] <= pat(i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_count     <= wr_count + 1;
      if (wr_addr < 12'd80) row0_wr <= row0_wr + 1;
    end
    rd_data <= mem[rd_addr];
  end

  task automatic load_pattern();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ascii_in = 8'h00;
    kbsig    = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    ascii_in = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic press(input int b);
    @(negedge clk) kbsig[b] = 1'b1;
    @(negedge clk) kbsig[b] = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 6000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ascii_in = 8'h00;
    kbsig    = 16'h0000;
    load_req = 1'b0;
    #1;
    load_pattern();
    @(negedge clk);
    tests_run++;
    if (cursor !== 12'd80 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: cursor=%0d in_ready=%b busy=%b, want 80 1 0", cursor, in_ready, busy);
    end
    tests_run++;
    if (wr_en !== 1'b0 || wr_addr !== 12'd0 || wr_data !== 8'h00 || rd_addr !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: wr_en=%b wr_addr=%0d wr_data=%h rd_addr=%0d, want all 0",
               wr_en, wr_addr, wr_data, rd_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_chars();
    send_char(8'h48);
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd80 || wr_data !== 8'h48 || cursor !== 12'd81) begin
      tests_failed++;
      $display("FAIL char_H: wr=%b (%0d,%h) cursor=%0d, want 1 (80,48) 81", wr_en, wr_addr, wr_data, cursor);
    end
    send_char(8'h69);
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd81 || wr_data !== 8'h69 || cursor !== 12'd82) begin
      tests_failed++;
      $display("FAIL char_i: wr=%b (%0d,%h) cursor=%0d, want 1 (81,69) 82", wr_en, wr_addr, wr_data, cursor);
    end
    @(negedge clk);
    tests_run++;
    if (wr_en !== 1'b0 || mem[80] !== 8'h48 || mem[81] !== 8'h69) begin
      tests_failed++;
      $display("FAIL char_mem: wr_en=%b mem80=%h mem81=%h, want 0 48 69", wr_en, mem[80], mem[81]);
    end
  endtask

  task automatic test_backspace();
    apply_reset();
    send_char(8'h08);
    tests_run++;
    if (wr_en !== 1'b0 || cursor !== 12'd80) begin
      tests_failed++;
      $display("FAIL bs_at_80: wr_en=%b cursor=%0d, want 0 80", wr_en, cursor);
    end
    for (int i = 0; i < 5; i++) press(5);
    tests_run++;
    if (cursor !== 12'd85) begin
      tests_failed++;
      $display("FAIL right_x5: cursor=%0d, want 85", cursor);
    end
    send_char(8'h08);
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd84 || wr_data !== 8'h20 || cursor !== 12'd84) begin
      tests_failed++;
      $display("FAIL bs_at_85: wr=%b (%0d,%h) cursor=%0d, want 1 (84,20) 84", wr_en, wr_addr, wr_data, cursor);
    end
    send_char(8'h01);
    tests_run++;
    if (wr_en !== 1'b0 || cursor !== 12'd84 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_code: wr_en=%b cursor=%0d busy=%b, want 0 84 0", wr_en, cursor, busy);
    end
    send_char(8'h0D);
    tests_run++;
    if (wr_en !== 1'b0 || cursor !== 12'd160) begin
      tests_failed++;
      $display("FAIL cr_row1: wr_en=%b cursor=%0d, want 0 160", wr_en, cursor);
    end
  endtask

  task automatic test_arrows();
    apply_reset();
    press(7);
    tests_run++;
    if (cursor !== 12'd160) begin
      tests_failed++;
      $display("FAIL down: cursor=%0d, want 160", cursor);
    end
    press(8);
    tests_run++;
    if (cursor !== 12'd80) begin
      tests_failed++;
      $display("FAIL up: cursor=%0d, want 80", cursor);
    end
    press(8);
    tests_run++;
    if (cursor !== 12'd80) begin
      tests_failed++;
      $display("FAIL up_sat: cursor=%0d, want 80", cursor);
    end
    @(negedge clk) kbsig[5] = 1'b1;
    repeat (10) @(negedge clk);
    kbsig[5] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cursor !== 12'd81) begin
      tests_failed++;
      $display("FAIL right_hold: cursor=%0d, want 81", cursor);
    end
    press(6);
    press(6);
    tests_run++;
    if (cursor !== 12'd80) begin
      tests_failed++;
      $display("FAIL left_sat: cursor=%0d, want 80", cursor);
    end
    // Arrow edge coincident with a character is dropped.
    @(negedge clk);
    kbsig[5] = 1'b1;
    in_valid = 1'b1;
    ascii_in = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    kbsig[5] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cursor !== 12'd80) begin
      tests_failed++;
      $display("FAIL arrow_with_valid: cursor=%0d, want 80", cursor);
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    int first;
    send_char(8'h0C);
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_start: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    wait_idle(n);
    tests_run++;
    if (n !== 2320) begin
      tests_failed++;
      $display("FAIL clear_cycles: busy for %0d cycles, want 2320", n);
    end
    @(negedge clk);
    bad   = 0;
    first = -1;
    for (int a = 0; a < 2400; a++) begin
      if (mem[a] !== ((a < 80) ? pat(a) : 8'h20)) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL clear_mem: %0d bad cells, first at %0d = %h, want 0 bad", bad, first,
               (first >= 0) ? mem[first] : 8'h00);
    end
    tests_run++;
    if (cursor !== 12'd80 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_cursor: cursor=%0d wr_en=%b, want 80 0", cursor, wr_en);
    end
  endtask

  task automatic test_scroll();
    int n;
    int bad;
    int first;
    logic [7:0] exp;
    for (int i = 0; i < 28; i++) press(7);
    for (int i = 0; i < 79; i++) press(5);
    tests_run++;
    if (cursor !== 12'd2399) begin
      tests_failed++;
      $display("FAIL nav_last: cursor=%0d, want 2399", cursor);
    end
    press(5);
    press(7);
    tests_run++;
    if (cursor !== 12'd2399) begin
      tests_failed++;
      $display("FAIL right_down_sat: cursor=%0d, want 2399", cursor);
    end
    load_pattern();
    send_char(8'h41);
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd2399 || wr_data !== 8'h41 || busy !== 1'b1 ||
        cursor !== 12'd2320) begin
      tests_failed++;
      $display("FAIL scroll_start: wr=%b (%0d,%h) busy=%b cursor=%0d, want 1 (2399,41) 1 2320",
               wr_en, wr_addr, wr_data, busy, cursor);
    end
    wait_idle(n);
    tests_run++;
    if (n !== 4560) begin
      tests_failed++;
      $display("FAIL scroll_cycles: busy for %0d cycles, want 4560", n);
    end
    @(negedge clk);
    bad   = 0;
    first = -1;
    for (int a = 0; a < 2400; a++) begin
      if (a < 80)        exp = pat(a);
      else if (a < 2319) exp = pat(a + 80);
      else if (a == 2319) exp = 8'h41;
      else               exp = 8'h20;
      if (mem[a] !== exp) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL scroll_mem: %0d bad cells, first at %0d = %h, want 0 bad", bad, first,
               (first >= 0) ? mem[first] : 8'h00);
    end
    tests_run++;
    if (cursor !== 12'd2320) begin
      tests_failed++;
      $display("FAIL scroll_cursor: cursor=%0d, want 2320", cursor);
    end
    send_char(8'h0D);
    tests_run++;
    if (busy !== 1'b1 || cursor !== 12'd2320 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL cr_last_row: busy=%b cursor=%0d wr_en=%b, want 1 2320 0", busy, cursor, wr_en);
    end
    wait_idle(n);
    tests_run++;
    if (n !== 4560) begin
      tests_failed++;
      $display("FAIL cr_scroll_cycles: busy for %0d cycles, want 4560", n);
    end
  endtask

  task automatic test_reset_mid_clear();
    int wc;
    send_char(8'h0C);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || cursor !== 12'd80 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_clear: busy=%b in_ready=%b cursor=%0d wr_en=%b, want 0 1 80 0",
               busy, in_ready, cursor, wr_en);
    end
    wc = wr_count;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (wr_count !== wc || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_writes_after_reset: writes=%0d busy=%b, want %0d 0", wr_count, busy, wc);
    end
  endtask

  task automatic test_row0();
    int bad;
    bad = 0;
    for (int a = 0; a < 80; a++) if (mem[a] !== pat(a)) bad++;
    tests_run++;
    if (row0_wr !== 0 || bad !== 0) begin
      tests_failed++;
      $display("FAIL row0_untouched: row0 writes=%0d changed cells=%0d, want 0 0", row0_wr, bad);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_chars();
    test_backspace();
    test_arrows();
    test_clear();
    test_scroll();
    test_reset_mid_clear();
    test_row0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
